// File: rtl/mux_scan_sequencer.sv
// Parallel-in/serial-out driver for an external WIDTH:1 mux: latches a word,
// then walks the mux select across every channel, one channel per accepted beat.
module mux_scan_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  output logic             ser_bit,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             frame_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] END_IDX   = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

  state_t state;
  logic   accept;
  logic   beat_fire;

  assign bit_last  = bit_valid & (mux_sel == END_IDX);
  assign beat_fire = bit_valid & bit_ready;

  // Taking a new word on the final beat gives back-to-back frames with no idle
  // cycle; rst_n gates the handshake so nothing is offered while held in reset.
  assign in_ready = rst_n & ((state == IDLE) | (bit_last & bit_ready));
  assign accept   = in_valid & in_ready;

  assign ser_bit = mux_in[mux_sel];

  // NOTE: every flop is written with <= so all updates in this block see the
  // pre-edge values of state/mux_sel regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mux_in     <= '0;
      mux_sel    <= '0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= beat_fire & bit_last;
      if (accept) begin
        // A reload takes priority over the return to IDLE on a final beat.
        mux_in    <= in_data;
        mux_sel   <= START_IDX;
        state     <= SCAN;
        bit_valid <= 1'b1;
      end else if (beat_fire) begin
        if (bit_last) begin
          state     <= IDLE;
          bit_valid <= 1'b0;
        end else if (MSB_FIRST) begin
          mux_sel <= mux_sel - SEL_W'(1);
        end else begin
          mux_sel <= mux_sel + SEL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: an LSB-first and an MSB-first instance
// share stimulus; a negedge monitor compares both against a queue of expected beats.
module tb_mux_scan_sequencer;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          bit_ready;

  logic          l_in_ready, l_ser_bit, l_bit_valid, l_bit_last, l_frame_done;
  logic [W-1:0]  l_mux_in;
  logic [SW-1:0] l_mux_sel;
  logic          m_in_ready, m_ser_bit, m_bit_valid, m_bit_last, m_frame_done;
  logic [W-1:0]  m_mux_in;
  logic [SW-1:0] m_mux_sel;

  int errors = 0;
  int checks = 0;

  mux_scan_sequencer #(.WIDTH(W), .SEL_W(SW), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .mux_in(l_mux_in), .mux_sel(l_mux_sel),
    .ser_bit(l_ser_bit), .bit_valid(l_bit_valid), .bit_ready(bit_ready),
    .bit_last(l_bit_last), .frame_done(l_frame_done)
  );

  mux_scan_sequencer #(.WIDTH(W), .SEL_W(SW), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .mux_in(m_mux_in), .mux_sel(m_mux_sel),
    .ser_bit(m_ser_bit), .bit_valid(m_bit_valid), .bit_ready(bit_ready),
    .bit_last(m_bit_last), .frame_done(m_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected beat: the k-th channel visited within a frame.
  typedef struct {
    logic [W-1:0]  word;
    logic [SW-1:0] sel_l;
    logic [SW-1:0] sel_m;
    logic          bit_l;
    logic          bit_m;
    logic          last;
  } beat_t;

  beat_t beats[$];
  logic  done_pending = 1'b0;

  always @(negedge clk) begin
    logic  rdy_exp;
    beat_t b;
    if (!rst_n) begin
      beats.delete();
      done_pending = 1'b0;
    end else begin
      rdy_exp = (beats.size() == 0) || (beats.size() == 1 && bit_ready);
      check("l_in_ready", 32'(l_in_ready), 32'(rdy_exp));
      check("m_in_ready", 32'(m_in_ready), 32'(rdy_exp));
      check("l_bit_valid", 32'(l_bit_valid), 32'(beats.size() != 0));
      check("m_bit_valid", 32'(m_bit_valid), 32'(beats.size() != 0));
      check("l_frame_done", 32'(l_frame_done), 32'(done_pending));
      check("m_frame_done", 32'(m_frame_done), 32'(done_pending));
      done_pending = 1'b0;
      if (beats.size() != 0) begin
        b = beats[0];
        check("l_mux_sel", 32'(l_mux_sel), 32'(b.sel_l));
        check("m_mux_sel", 32'(m_mux_sel), 32'(b.sel_m));
        check("l_ser_bit", 32'(l_ser_bit), 32'(b.bit_l));
        check("m_ser_bit", 32'(m_ser_bit), 32'(b.bit_m));
        check("l_bit_last", 32'(l_bit_last), 32'(b.last));
        check("m_bit_last", 32'(m_bit_last), 32'(b.last));
        check("l_mux_in", 32'(l_mux_in), 32'(b.word));
        check("m_mux_in", 32'(m_mux_in), 32'(b.word));
        if (bit_ready) begin
          void'(beats.pop_front());
          done_pending = b.last;
        end
      end else begin
        check("l_bit_last_idle", 32'(l_bit_last), 32'(0));
        check("m_bit_last_idle", 32'(m_bit_last), 32'(0));
      end
      if (in_valid && rdy_exp) begin
        for (int k = 0; k < W; k++) begin
          b.word  = in_data;
          b.sel_l = SW'(k);
          b.sel_m = SW'(W - 1 - k);
          b.bit_l = in_data[k];
          b.bit_m = in_data[W - 1 - k];
          b.last  = (k == W - 1);
          beats.push_back(b);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the handshake completes.
  task automatic send(input logic [W-1:0] word);
    logic acc;
    in_data  = word;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = l_in_ready;
      cycle();
      if (acc) return;
    end
    check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_sel(input logic [SW-1:0] sel);
    for (int i = 0; i < 40; i++) begin
      if (l_bit_valid && l_mux_sel == sel) return;
      cycle();
    end
    check("wait_sel_timeout", 32'(l_mux_sel), 32'(sel));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_l_in_ready"}, 32'(l_in_ready), 32'(0));
    check({tag, "_m_in_ready"}, 32'(m_in_ready), 32'(0));
    check({tag, "_l_mux_in"}, 32'(l_mux_in), 32'(0));
    check({tag, "_l_mux_sel"}, 32'(l_mux_sel), 32'(0));
    check({tag, "_m_mux_sel"}, 32'(m_mux_sel), 32'(0));
    check({tag, "_l_bit_valid"}, 32'(l_bit_valid), 32'(0));
    check({tag, "_m_bit_valid"}, 32'(m_bit_valid), 32'(0));
    check({tag, "_l_ser_bit"}, 32'(l_ser_bit), 32'(0));
    check({tag, "_l_bit_last"}, 32'(l_bit_last), 32'(0));
    check({tag, "_l_frame_done"}, 32'(l_frame_done), 32'(0));
    check({tag, "_m_frame_done"}, 32'(m_frame_done), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    bit_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    #19;
    rst_n = 1'b1;
    cycle();

    // LSB/MSB basic frame.
    bit_ready = 1'b1;
    send(8'b1000_1010);
    in_valid = 1'b0;
    repeat (10) cycle();

    // Backpressure at channel 2.
    send(8'b1000_1010);
    in_valid = 1'b0;
    wait_sel(3'd2);
    bit_ready = 1'b0;
    repeat (3) cycle();
    bit_ready = 1'b1;
    repeat (10) cycle();

    // Back-to-back frames with in_valid held high.
    send(8'b1000_0000);
    send(8'b1001_0000);
    in_valid = 1'b0;
    repeat (10) cycle();

    // Busy rejection: a one-cycle pulse mid-frame, then a properly held word.
    send(8'hA5);
    in_valid = 1'b0;
    wait_sel(3'd3);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    send(8'h3C);
    in_valid = 1'b0;
    repeat (10) cycle();

    // Asynchronous reset mid-frame.
    send(8'hFF);
    in_valid = 1'b0;
    wait_sel(3'd5);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) cycle();
    check_reset_outputs("inrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    cycle();
    send(8'b1000_1010);
    in_valid = 1'b0;
    repeat (10) cycle();

    // Randomised traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      in_data   = W'($urandom);
      in_valid  = ($urandom_range(0, 2) == 0);
      bit_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    in_valid  = 1'b0;
    bit_ready = 1'b1;
    repeat (12) cycle();
    check("drain_l_bit_valid", 32'(l_bit_valid), 32'(0));
    check("drain_m_in_ready", 32'(m_in_ready), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream driver for the 8:1 mux. It accepts a parallel word on a valid/ready handshake and holds it on the mux data inputs. It then steps the mux select through every channel, one channel per accepted beat, so the mux serialises the word onto its single output. It also produces an internal copy of the selected bit, plus beat and frame framing signals, so it can stand alone as a parallel-in/serial-out stage.

Parameters:
WIDTH, 8, number of mux channels (data word width); power of two, >= 2
SEL_W, 3, select width; must equal log2(WIDTH)
MSB_FIRST, 0, 0 = select counts 0 up to WIDTH-1; 1 = select counts WIDTH-1 down to 0

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  WIDTH  parallel word to serialise
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
mux_in  output  WIDTH  held word, wired to the mux data input
mux_sel  output  SEL_W  current channel, wired to the mux select
ser_bit  output  1  equals mux_in[mux_sel]; internal reference of the mux output
bit_valid  output  1  ser_bit/mux_sel are a live beat
bit_ready  input  1  downstream accepts the current beat
bit_last  output  1  current beat is the final channel of the frame
frame_done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low, and release is synchronous to clk.
- Reset values: state=IDLE, mux_in=0, mux_sel=0, bit_valid=0, frame_done=0, bit_last=0, ser_bit=0. in_ready is forced 0 while rst_n=0.
- FSM states:
  - IDLE: bit_valid=0; in_ready=1.
  - SCAN: bit_valid=1.
- Accept: a word is accepted on any cycle with in_valid & in_ready. On accept:
  - mux_in <= in_data.
  - mux_sel <= start index: 0 if MSB_FIRST=0, WIDTH-1 if MSB_FIRST=1.
  - state <= SCAN.
- SCAN, beat accepted (bit_valid & bit_ready):
  - not last: mux_sel steps by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
  - last: state <= IDLE, and frame_done=1 on the next cycle.
- SCAN, bit_ready=0: mux_sel, mux_in and ser_bit hold unchanged for any number of cycles.
- bit_last = bit_valid & (mux_sel == end index), where end index is WIDTH-1 for MSB_FIRST=0 and 0 for MSB_FIRST=1.
- in_ready = (state==IDLE) | (state==SCAN & bit_last & bit_ready). This gives back-to-back frames with no bubble:
  - On an accept coinciding with the last beat, the next cycle is SCAN at the start index with the new word.
  - frame_done still pulses for the finished frame.
- Latency: word accepted at edge N; first beat valid in cycle N+1; WIDTH beats minimum; frame_done in the cycle after the last beat is accepted.
- in_valid while busy and not on the last accepted beat: not accepted; the source must hold in_data/in_valid (standard valid/ready). mux_in never changes mid-frame.
- mux_sel never wraps: it never goes beyond the end index; the transition to IDLE/reload happens instead.
- In IDLE, mux_sel and mux_in retain their last values; ser_bit stays combinational from them, but bit_valid=0 marks it don't-care.
- Reset mid-frame: the frame is aborted, all outputs return to reset values, and no frame_done pulse is produced.
- ser_bit is purely combinational from the registered mux_in and mux_sel. There is no internal path from in_data to any output.

Test Plan:
- LSB-first basic: reset, then accept in_data=8'b10001010 with bit_ready=1 -> mux_sel 0..7 on 8 consecutive cycles; ser_bit=0,1,0,1,0,0,0,1; bit_last only at mux_sel=7; frame_done one cycle later; in_ready=1 afterwards.
- Backpressure: same word, bit_ready=0 for 3 cycles at mux_sel=2 -> mux_sel stays 2 and ser_bit stays 0 throughout; frame completes in 11 beat cycles; bit_valid never drops mid-frame.
- Back-to-back: in_valid held high with 8'b10000000 then 8'b10010000, bit_ready=1 -> 16 consecutive valid beats with no bubble. Second frame starts at mux_sel=0, ser_bit=0 and has bit 4 = 1; frame_done pulses twice.
- MSB_FIRST=1: in_data=8'b10001010 -> mux_sel 7..0, ser_bit=1,0,0,0,1,0,1,0; bit_last at mux_sel=0.
- Busy rejection: in_valid pulsed at mux_sel=3 -> in_ready=0; mux_in unchanged; the word is accepted only when held until the last beat.
- Reset mid-frame: drop rst_n at mux_sel=5 -> outputs clear immediately, no frame_done. After release, a new word starts cleanly at mux_sel=0.
